// File: rtl/pipe_sink.sv
// Receive-side endpoint for pipe_stall: FWFT FIFO with registered ready and sticky overflow.
// Define PIPE_SINK_STATS_EN to add saturating beat_cnt/stall_cnt outputs.
module pipe_sink #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             ivalid,
  output logic             rdy,
  output logic             ovalid,
  output logic [WIDTH-1:0] dout,
  input  logic             ordy,
  output logic             overflow
`ifdef PIPE_SINK_STATS_EN
  ,
  output logic [15:0]      beat_cnt,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             rdy_q, rdy_d;
  logic             overflow_q, overflow_d;
  logic             full, push, pop;

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a beat alongside it.
  always_comb begin
    full       = (count_q == FullCnt);
    pop        = (count_q != '0) & ordy;
    push       = ivalid & (~full | pop);
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    rdy_d      = ((FullCnt - count_d) >= CW'(2));
    overflow_d = overflow_q | (ivalid & full & ~pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rdy_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rdy_q      <= rdy_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; entries are only ever read while count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign rdy      = rdy_q;
  assign ovalid   = (count_q != '0);
  assign dout     = mem_q[rd_ptr_q];
  assign overflow = overflow_q;

`ifdef PIPE_SINK_STATS_EN
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (push && (beat_cnt_q != 16'hFFFF)) begin
      beat_cnt_d = beat_cnt_q + 16'd1;
    end
    if (ovalid && !ordy && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign beat_cnt  = beat_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_sink.sv
// Scoreboard bench for pipe_sink: directed beats queue expected data, a monitor checks each pop.
module tb_pipe_sink;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       ivalid;
  logic       rdy;
  logic       ovalid;
  logic [7:0] dout;
  logic       ordy;
  logic       overflow;
`ifdef PIPE_SINK_STATS_EN
  logic [15:0] beat_cnt;
  logic [15:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int stallSeen = 0;
  logic [7:0] expQ[$];

  pipe_sink #(.WIDTH(8), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .ivalid   (ivalid),
    .rdy      (rdy),
    .ovalid   (ovalid),
    .dout     (dout),
    .ordy     (ordy),
    .overflow (overflow)
`ifdef PIPE_SINK_STATS_EN
    ,
    .beat_cnt (beat_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs are held for exactly one rising edge; returns 1ns after that edge.
  task automatic applyStimulus(input logic iv, input logic [7:0] d, input logic od);
    ivalid = iv;
    din    = d;
    ordy   = od;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every pop the DUT will take on the next edge must match the scoreboard head.
  always @(negedge clk) begin
    if (rst && ovalid && !ordy) stallSeen++;
    if (rst && ovalid && ordy) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL pop_unexpected: got %0h expected none", dout);
      end else begin
        checkOutput("pop_data", {24'd0, dout}, {24'd0, expQ.pop_front()});
      end
    end
  end

  initial begin
    int sent;
    int budget;
    rst = 1'b0; ivalid = 1'b0; din = '0; ordy = 1'b0;

    // Reset then idle
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("reset_rdy", {31'd0, rdy}, 32'd0);
    checkOutput("reset_ovalid", {31'd0, ovalid}, 32'd0);
    checkOutput("reset_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("release_rdy_before_edge", {31'd0, rdy}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("release_rdy_after_edge", {31'd0, rdy}, 32'd1);

    // Single beat
    expQ.push_back(8'hA5);
    applyStimulus(1'b1, 8'hA5, 1'b1);
    checkOutput("single_ovalid", {31'd0, ovalid}, 32'd1);
    checkOutput("single_dout", {24'd0, dout}, 32'hA5);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("single_drained", {31'd0, ovalid}, 32'd0);

    // Three beats with consumer stalled: ready drops after the third (skid) beat
    for (int i = 1; i <= 3; i++) begin
      expQ.push_back(8'(i));
      applyStimulus(1'b1, 8'(i), 1'b0);
      checkOutput($sformatf("skid_rdy_after_%0d", i), {31'd0, rdy}, (i < 3) ? 32'd1 : 32'd0);
    end
    checkOutput("skid_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("skid_head", {24'd0, dout}, 32'h01);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("skid_drained", {31'd0, ovalid}, 32'd0);
    checkOutput("skid_rdy_back", {31'd0, rdy}, 32'd1);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      expQ.push_back(8'h10 + 8'(i));
      applyStimulus(1'b1, 8'h10 + 8'(i), 1'b0);
    end
    checkOutput("full_rdy", {31'd0, rdy}, 32'd0);
    checkOutput("full_head", {24'd0, dout}, 32'h10);
    expQ.push_back(8'hEE);
    applyStimulus(1'b1, 8'hEE, 1'b1);
    checkOutput("pushpop_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("pushpop_head", {24'd0, dout}, 32'h11);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("pushpop_still_one", {31'd0, ovalid}, 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("pushpop_drained", {31'd0, ovalid}, 32'd0);

    // Reset mid-stream discards buffered beats immediately
    applyStimulus(1'b1, 8'h91, 1'b0);
    applyStimulus(1'b1, 8'h92, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("midreset_ovalid", {31'd0, ovalid}, 32'd0);
    checkOutput("midreset_rdy", {31'd0, rdy}, 32'd0);
    ivalid = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1);
    stallSeen = 0;
    rst = 1'b1;
    #1;
    checkOutput("midreset_rdy_hold", {31'd0, rdy}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("midreset_rdy_up", {31'd0, rdy}, 32'd1);
    checkOutput("midreset_no_data", {31'd0, ovalid}, 32'd0);

    // Stream 10 beats, producer obeys registered rdy, consumer toggles every cycle
    sent = 0;
    budget = 0;
    while (sent < 10 && budget < 200) begin
      if (rdy) begin
        expQ.push_back(8'h20 + 8'(sent));
        applyStimulus(1'b1, 8'h20 + 8'(sent), budget[0]);
        sent++;
      end else begin
        applyStimulus(1'b0, 8'h00, budget[0]);
      end
      budget++;
    end
    checkOutput("stream_all_sent", 32'(sent), 32'd10);
    budget = 0;
    while (expQ.size() != 0 && budget < 50) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      budget++;
    end
    checkOutput("stream_queue_empty", 32'(expQ.size()), 32'd0);
    checkOutput("stream_ovalid", {31'd0, ovalid}, 32'd0);
    checkOutput("stream_overflow", {31'd0, overflow}, 32'd0);
`ifdef PIPE_SINK_STATS_EN
    checkOutput("stats_beat_cnt", {16'd0, beat_cnt}, 32'd10);
    checkOutput("stats_stall_cnt", {16'd0, stall_cnt}, 32'(stallSeen));
`endif

    // Overflow: beat into a full FIFO is dropped and the flag sticks
    for (int i = 0; i < 4; i++) begin
      expQ.push_back(8'h60 + 8'(i));
      applyStimulus(1'b1, 8'h60 + 8'(i), 1'b0);
    end
    checkOutput("preovf_flag", {31'd0, overflow}, 32'd0);
    applyStimulus(1'b1, 8'h55, 1'b0);
    checkOutput("ovf_flag", {31'd0, overflow}, 32'd1);
    checkOutput("ovf_head", {24'd0, dout}, 32'h60);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("ovf_sticky", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("ovf_drained", {31'd0, ovalid}, 32'd0);
    checkOutput("ovf_sticky_after_drain", {31'd0, overflow}, 32'd1);
    checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_sink.md
Name: pipe_sink

Overview:
- Receive-side endpoint for the pipe_stall output interface.
- Accepts beats qualified by ivalid (the upstream ovalid) and drives rdy back to the producer.
- Beats are buffered in a small first-word-fall-through FIFO and presented to a local consumer on a valid/ready port.
- Sized so that one in-flight beat after rdy drops (the producer's registered-rdy skid) is never lost.

Parameters:
- WIDTH, 8, data width of din/dout.
- DEPTH, 4, FIFO entries. Power of two, minimum 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- din  input  WIDTH  beat data from producer.
- ivalid  input  1  beat present this cycle (producer ovalid).
- rdy  output  1  ready to producer, registered.
- ovalid  output  1  FIFO non-empty; dout valid.
- dout  output  WIDTH  head-of-FIFO data.
- ordy  input  1  consumer accepts head this cycle.
- overflow  output  1  sticky: a beat was dropped.

Behaviour:
- Reset (rst=0, asynchronous): count=0, pointers=0, rdy=0, ovalid=0, overflow=0. dout is don't-care while ovalid=0.
- Beat rule: every cycle with ivalid=1 is exactly one beat, independent of rdy.
  - push = ivalid & (count<DEPTH | pop).
  - Data is written at mem[wr_ptr] on the clock edge.
- Pop rule: pop = ovalid & ordy. rd_ptr advances on the edge.
  - dout = mem[rd_ptr], combinational from storage (FWFT).
- Latency: a beat pushed at edge N appears on dout/ovalid after edge N when the FIFO was empty. Minimum latency is one cycle; there is no combinational din-to-dout path.
- count_next = count + push - pop. Width is clog2(DEPTH)+1. It never exceeds DEPTH.
- ovalid = (count != 0).
- rdy is registered: rdy <= (DEPTH - count_next >= 2).
  - First rdy=1 is at the first edge after reset release.
  - The margin of 2 absorbs the single beat the producer may still emit in the cycle after rdy falls.
- Full with simultaneous push and pop: both occur, count stays at DEPTH, and data order is preserved.
- Empty with ordy=1 and no ovalid: no pop and no pointer movement.
- Empty with push in the same cycle: no pop. ovalid rises the next cycle.
- Overflow: when ivalid=1, count==DEPTH and pop=0, the beat is dropped and overflow is set to 1. overflow stays set until reset; FIFO contents are unchanged.
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Reset asserted mid-stream: all state clears immediately and buffered beats are discarded. rdy stays 0 until the first edge after release.

Optional Feature:
- Macro PIPE_SINK_STATS_EN.
- Defined:
  - Adds output beat_cnt [15:0], counting accepted pushes.
  - Adds output stall_cnt [15:0], counting cycles with ovalid=1 and ordy=0.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Not defined: neither port exists and no counter logic is present.

Test Plan:
- Reset then idle -> rdy=0 while rst=0; rdy=1 one edge after release; ovalid=0; overflow=0.
- Single beat din=8'hA5, ivalid=1 for one cycle, ordy=1 -> next cycle ovalid=1, dout=8'hA5; the following cycle ovalid=0.
- ordy=0, beats 8'h01..8'h03 on consecutive cycles (DEPTH=4):
  - rdy falls the cycle after the 2nd beat is pushed.
  - 3rd beat (skid) is accepted.
  - count=3, overflow=0.
  - Then ordy=1 -> dout shows 01, 02, 03 in order.
- Fill to 4 with ordy=0, then ivalid=1 din=8'hEE with ordy=1 in the same cycle -> push and pop both occur; count stays 4; 8'hEE is delivered last; overflow=0.
- Fill to 4 with ordy=0, then ivalid=1 din=8'h55 -> beat dropped, overflow=1 and stays 1; dout still shows the original head.
- Stream 10 beats with ordy toggling every cycle (DEPTH=4):
  - Pointers wrap with no loss or duplication.
  - With PIPE_SINK_STATS_EN, beat_cnt=10 and stall_cnt equals the observed ovalid&~ordy cycles.
